jtframe_dwnld: RTL and testbench

Consumes the byte-wide ioctl download stream produced by the SPI data receiver and turns it into 16-bit SDRAM write requests for the SDRAM controller's programming port. It packs even/odd byte pairs into words, flushes orphan bytes with byte masks, and buffers requests in a small FIFO so the controller can stall with `prog_rdy`. It sits between the download receiver and `jtframe_sdram` in every core that loads ROMs through the MiST(er) download path.

---
 rtl/jtframe_dwnld_pkg.sv | 45 ++++
 rtl/jtframe_dwnld_fifo.sv | 65 ++++++
 rtl/jtframe_dwnld.sv | 161 ++++++++++++++++
 tb/tb_jtframe_dwnld.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ioctl-to-SDRAM download packer.
// Lane placement helpers take the swap setting so both builds share them.
package jtframe_dwnld_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } pack_st_e;

  // Active-low DQM masks: bit0 low byte, bit1 high byte
  localparam logic [1:0] MASK_FULL = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  mask;
  } prog_word_t;

  localparam prog_word_t WORD_IDLE = '{data: 16'h0000, mask: MASK_NONE};

  function automatic prog_word_t lane_word(
    input logic       swap,
    input logic       odd,
    input logic [7:0] b
  );
    prog_word_t w;
    w.data = (odd ^ swap) ? {b, 8'h00} : {8'h00, b};
    w.mask = (odd ^ swap) ? MASK_HI : MASK_LO;
    return w;
  endfunction

  function automatic prog_word_t pair_word(
    input logic       swap,
    input logic [7:0] ev,
    input logic [7:0] od
  );
    prog_word_t w;
    w.data = swap ? {ev, od} : {od, ev};
    w.mask = MASK_FULL;
    return w;
  endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small request FIFO; head shows an idle word (mask 11) while empty.
// A push into a full FIFO is accepted only if a pop frees a slot.
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
#(
  parameter int WAW   = 21,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [WAW-1:0] push_addr,
  input  prog_word_t     push_word,
  input  logic           pop,
  output logic           full,
  output logic           empty,
  output logic [WAW-1:0] head_addr,
  output prog_word_t     head_word
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WAW-1:0] addr_mem [DEPTH];
  prog_word_t     word_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr_q] <= push_addr;
      word_mem[wr_ptr_q] <= push_word;
    end
  end

  assign head_addr = empty ? '0 : addr_mem[rd_ptr_q];
  assign head_word = empty ? WORD_IDLE : word_mem[rd_ptr_q];

endmodule

// File: rtl/jtframe_dwnld.sv
// Packs the ioctl byte stream into masked 16-bit SDRAM program writes.
// Define JTFRAME_DWNLD_SWAP_EN to put even bytes in the high lane.
module jtframe_dwnld
  import jtframe_dwnld_pkg::*;
#(
  parameter int AW    = 22,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic [AW-2:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic          dwnld_busy,
  output logic          overflow
);

`ifdef JTFRAME_DWNLD_SWAP_EN
  localparam logic SWAP = 1'b1;
`else
  localparam logic SWAP = 1'b0;
`endif

  localparam int WAW = AW - 1;

  pack_st_e       st_q, st_d;
  logic [WAW-1:0] hold_addr_q, hold_addr_d;
  logic [7:0]     hold_byte_q, hold_byte_d;
  logic           pend_q, pend_d;
  logic [WAW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]     pend_byte_q, pend_byte_d;
  logic           dl_q, ovf_q, ovf_d;

  logic           wr, odd, fall, push, pop, full, empty;
  logic [WAW-1:0] waddr, push_addr;
  prog_word_t     push_word, head_word;

  assign wr    = ioctl_wr & downloading;
  assign odd   = ioctl_addr[0];
  assign waddr = ioctl_addr[AW-1:1];
  assign fall  = dl_q & ~downloading;
  assign pop   = ~empty & prog_rdy;

  always_comb begin
    st_d        = st_q;
    hold_addr_d = hold_addr_q;
    hold_byte_d = hold_byte_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    pend_byte_d = pend_byte_q;
    push        = 1'b0;
    push_addr   = waddr;
    push_word   = lane_word(SWAP, odd, ioctl_data);
    if (pend_q) begin
      // Second push of a split pair; the packer is EMPTY here
      push      = 1'b1;
      push_addr = pend_addr_q;
      push_word = lane_word(SWAP, 1'b1, pend_byte_q);
      if (wr && odd) begin
        pend_d      = 1'b1;
        pend_addr_d = waddr;
        pend_byte_d = ioctl_data;
      end else if (wr) begin
        st_d        = HOLD;
        hold_addr_d = waddr;
        hold_byte_d = ioctl_data;
      end
    end else begin
      case (st_q)
        EMPTY: begin
          if (wr && odd) begin
            push = 1'b1;
          end else if (wr) begin
            st_d        = HOLD;
            hold_addr_d = waddr;
            hold_byte_d = ioctl_data;
          end
        end
        HOLD: begin
          if (wr && odd && waddr == hold_addr_q) begin
            push      = 1'b1;
            push_addr = hold_addr_q;
            push_word = pair_word(SWAP, hold_byte_q, ioctl_data);
            st_d      = EMPTY;
          end else if (wr) begin
            push      = 1'b1;
            push_addr = hold_addr_q;
            push_word = lane_word(SWAP, 1'b0, hold_byte_q);
            if (odd) begin
              st_d        = EMPTY;
              pend_d      = 1'b1;
              pend_addr_d = waddr;
              pend_byte_d = ioctl_data;
            end else begin
              hold_addr_d = waddr;
              hold_byte_d = ioctl_data;
            end
          end else if (fall) begin
            push      = 1'b1;
            push_addr = hold_addr_q;
            push_word = lane_word(SWAP, 1'b0, hold_byte_q);
            st_d      = EMPTY;
          end
        end
        default: st_d = EMPTY;
      endcase
    end
    ovf_d = ovf_q | (push & full & ~pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= EMPTY;
      hold_addr_q <= '0;
      hold_byte_q <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_byte_q <= '0;
      dl_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      hold_addr_q <= hold_addr_d;
      hold_byte_q <= hold_byte_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_byte_q <= pend_byte_d;
      dl_q        <= downloading;
      ovf_q       <= ovf_d;
    end
  end

  jtframe_dwnld_fifo #(
    .WAW   (WAW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (push_addr),
    .push_word (push_word),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head_addr (prog_addr),
    .head_word (head_word)
  );

  assign prog_data  = head_word.data;
  assign prog_mask  = head_word.mask;
  assign prog_we    = ~empty;
  assign overflow   = ovf_q;
  assign dwnld_busy = downloading | (st_q == HOLD) | pend_q | ~empty;

endmodule

// File: tb/tb_jtframe_dwnld.sv
// Bench for jtframe_dwnld: directed cases plus random byte streams
// compared against a pairing-rule model of the expected word writes.
module tb_jtframe_dwnld;

  localparam int AW    = 22;
  localparam int DEPTH = 4;

`ifdef JTFRAME_DWNLD_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          downloading;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic [AW-2:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic          prog_we;
  logic          prog_rdy;
  logic          dwnld_busy;
  logic          overflow;

  always #5 clk = ~clk;

  jtframe_dwnld #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .prog_rdy    (prog_rdy),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  typedef struct {
    int unsigned addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         act_q[$];
  int unsigned win_a[$];
  logic [7:0]  win_d[$];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          we_cyc   = 0;
  int unsigned cyc      = 0;
  bit          rnd_rdy  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (prog_we === 1'b1) we_cyc++;
    if (prog_we === 1'b1 && prog_rdy === 1'b1) begin
      w.addr = prog_addr;
      w.data = prog_data;
      w.mask = prog_mask;
      act_q.push_back(w);
    end
  end

  // Expected writes for one window: an even byte followed directly by
  // its odd partner is one full word, every other byte stands alone.
  function automatic wr_t orphan(int unsigned a, logic [7:0] d);
    wr_t w;
    bit  hi;
    hi     = (a % 2 == 1) ^ SWAP;
    w.addr = a / 2;
    w.data = hi ? {d, 8'h00} : {8'h00, d};
    w.mask = hi ? 2'b01 : 2'b10;
    return w;
  endfunction

  task automatic model_window();
    int  i;
    wr_t w;
    i = 0;
    while (i < win_a.size()) begin
      if (win_a[i] % 2 == 0 && i + 1 < win_a.size()
          && win_a[i+1] == win_a[i] + 1) begin
        w.addr = win_a[i] / 2;
        w.data = SWAP ? {win_d[i], win_d[i+1]} : {win_d[i+1], win_d[i]};
        w.mask = 2'b00;
        exp_q.push_back(w);
        i += 2;
      end else begin
        exp_q.push_back(orphan(win_a[i], win_d[i]));
        i += 1;
      end
    end
    win_a.delete();
    win_d.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_rdy) prog_rdy = cyc[0] | ($urandom_range(0, 1) == 1);
  endtask

  task automatic wr_byte(input int unsigned a, input logic [7:0] d);
    ioctl_addr = AW'(a);
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (downloading) begin
      win_a.push_back(a);
      win_d.push_back(d);
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_window();
    downloading = 1'b0;
    model_window();
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (!dwnld_busy) break;
      tick();
    end
    check("drain_timeout", {31'd0, dwnld_busy}, 0);
  endtask

  task automatic compare(input string tag);
    wr_t e, a;
    logic [15:0] lm;
    check({tag, "_count"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a  = act_q.pop_front();
      e  = exp_q.pop_front();
      lm = {{8{~e.mask[1]}}, {8{~e.mask[0]}}};
      check({tag, "_addr"}, a.addr, e.addr);
      check({tag, "_mask"}, {30'd0, a.mask}, {30'd0, e.mask});
      check({tag, "_data"}, {16'd0, a.data & lm}, {16'd0, e.data & lm});
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned a;
    rst         = 1'b1;
    downloading = 1'b0;
    ioctl_addr  = '0;
    ioctl_data  = '0;
    ioctl_wr    = 1'b0;
    prog_rdy    = 1'b0;
    #12;
    check("rst_we", {31'd0, prog_we}, 0);
    check("rst_addr", prog_addr, 0);
    check("rst_data", prog_data, 0);
    check("rst_mask", prog_mask, 2'b11);
    check("rst_busy", dwnld_busy, 0);
    check("rst_ovf", overflow, 0);
    downloading = 1'b1;
    #1;
    check("rst_busy_dl", dwnld_busy, 1);
    tick();
    rst = 1'b0;
    tick();

    // full pair
    prog_rdy = 1'b1;
    we_cyc   = 0;
    wr_byte(0, 8'hAA);
    check("pair_we_early", prog_we, 0);
    wr_byte(1, 8'h55);
    check("pair_latency_we", prog_we, 1);
    check("pair_latency_addr", prog_addr, 0);
    repeat (3) tick();
    check("pair_we_cycles", we_cyc, 1);
    end_window();
    drain();
    compare("pair");

    // single even byte flushed by end of download
    downloading = 1'b1;
    tick();
    wr_byte(4, 8'h11);
    tick();
    check("flush_held_we", prog_we, 0);
    check("flush_held_busy", dwnld_busy, 1);
    end_window();
    drain();
    check("flush_busy_low", dwnld_busy, 0);
    compare("flush");

    // non-pairing bytes: held byte, then split odd byte
    downloading = 1'b1;
    tick();
    wr_byte(6, 8'h22);
    wr_byte(9, 8'h33);
    end_window();
    drain();
    compare("split");

    // ignored outside the download window
    wr_byte(8, 8'h77);
    repeat (4) tick();
    check("ignored_writes", act_q.size(), 0);
    check("ignored_busy", dwnld_busy, 0);

    // stalled controller overflow
    prog_rdy    = 1'b0;
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) wr_byte(i, 8'($urandom));
    repeat (3) tick();
    check("ovf_flag", overflow, 1);
    check("ovf_we_held", prog_we, 1);
    check("ovf_head_addr", prog_addr, 0);
    check("ovf_head_mask", prog_mask, 2'b00);
    end_window();
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    prog_rdy = 1'b1;
    drain();
    check("ovf_sticky", overflow, 1);
    compare("ovf");

    // reset mid-download with entries queued and a byte held
    prog_rdy    = 1'b0;
    downloading = 1'b1;
    tick();
    for (int i = 20; i < 26; i++) wr_byte(i, 8'($urandom));
    wr_byte(26, 8'h5A);
    tick();
    check("mid_rst_we_before", prog_we, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_we_async", prog_we, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_mask", prog_mask, 2'b11);
    check("mid_rst_busy", dwnld_busy, 1);
    win_a.delete();
    win_d.delete();
    exp_q.delete();
    tick();
    tick();
    rst      = 1'b0;
    prog_rdy = 1'b1;
    repeat (10) tick();
    downloading = 1'b0;
    repeat (5) tick();
    check("mid_rst_no_writes", act_q.size(), 0);
    check("mid_rst_busy_low", dwnld_busy, 0);
    check("mid_rst_ovf_after", overflow, 0);

    // random streams with a stalling controller
    rnd_rdy = 1'b1;
    for (int w = 0; w < 4; w++) begin
      downloading = 1'b1;
      tick();
      a = $urandom_range(0, 4095);
      for (int k = 0; k < 30; k++) begin
        if (k > 0) a = ($urandom_range(0, 9) < 6) ? a + 1 : $urandom_range(0, 4095);
        wr_byte(a, 8'($urandom));
        repeat ($urandom_range(1, 3)) tick();
      end
      end_window();
      drain();
      compare("rand");
    end
    check("rand_no_ovf", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
